// File: rtl/fdiv.sv
// Iterative IEEE-754 single-precision divider: restoring radix-2 core with full rounding and flags.
// Optional build macro FDIV_SPECIAL_FAST_EN: special operands finish straight out of PREP.
module fdiv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  rm,
    output logic        busy,
    output logic        done,
    output logic [31:0] s,
    output logic        Invalid,
    output logic        DZ,
    output logic        OF,
    output logic        UF,
    output logic        NX
);

    // state | meaning
    // IDLE  | waiting for start; operands latched on the accepting edge
    // PREP  | unpack, normalize subnormals, classify specials, exponent difference
    // DIV   | 26 restoring-division iterations, one quotient bit each
    // ROUND | denormal align, round, pack, flags, done pulse
    typedef enum logic [1:0] {IDLE, PREP, DIV, ROUND} state_t;

    state_t state, state_nx;

    logic [31:0]        a_q, b_q;
    logic [1:0]         rm_q;
    logic               sign_q;
    logic signed [11:0] exp_q;
    logic [23:0]        mb_q;
    logic [25:0]        rem_q;
    logic [25:0]        quo_q;
    logic [4:0]         cnt_q;
    logic               spec_q, spec_inv_q, spec_dz_q;
    logic [31:0]        spec_res_q;

    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 24; i++) begin
            if (v[i]) n = 5'(23 - i);
        end
        return n;
    endfunction

    function automatic logic rnd_inc(input logic [1:0] mode, input logic sgn,
                                     input logic lsb, input logic g, input logic r,
                                     input logic st);
        logic inc;
        case (mode)
            2'b00:   inc = g & (r | st | lsb);
            2'b01:   inc = sgn & (g | r | st);
            2'b10:   inc = ~sgn & (g | r | st);
            default: inc = 1'b0;
        endcase
        return inc;
    endfunction

    // PREP datapath
    logic [7:0]         ea_f, eb_f;
    logic               a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic [23:0]        siga, sigb, ma, mb;
    logic [4:0]         lza, lzb;
    logic signed [11:0] expa, expb, ediff;
    logic               m_lt, sgn;
    logic               sp_nan, sp_dz, sp_inf, sp_zero, sp_any;
    logic [31:0]        sp_res;

    always_comb begin
        ea_f   = a_q[30:23];
        eb_f   = b_q[30:23];
        a_zero = (ea_f == 8'd0) && (a_q[22:0] == 23'd0);
        b_zero = (eb_f == 8'd0) && (b_q[22:0] == 23'd0);
        a_inf  = (ea_f == 8'hff) && (a_q[22:0] == 23'd0);
        b_inf  = (eb_f == 8'hff) && (b_q[22:0] == 23'd0);
        a_nan  = (ea_f == 8'hff) && (a_q[22:0] != 23'd0);
        b_nan  = (eb_f == 8'hff) && (b_q[22:0] != 23'd0);
        siga   = {ea_f != 8'd0, a_q[22:0]};
        sigb   = {eb_f != 8'd0, b_q[22:0]};
        lza    = lzc24(siga);
        lzb    = lzc24(sigb);
        ma     = siga << lza;
        mb     = sigb << lzb;
        m_lt   = ma < mb;
        sgn    = a_q[31] ^ b_q[31];
        expa   = $signed({4'd0, (ea_f == 8'd0) ? 8'd1 : ea_f}) - $signed({7'd0, lza});
        expb   = $signed({4'd0, (eb_f == 8'd0) ? 8'd1 : eb_f}) - $signed({7'd0, lzb});
        // a smaller significand is pre-doubled so the quotient always lands in [1,2)
        ediff  = expa - expb + 12'sd127 - (m_lt ? 12'sd1 : 12'sd0);

        sp_nan  = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
        sp_dz   = b_zero & ~a_zero & ~a_inf;
        sp_inf  = a_inf & ~b_inf;
        sp_zero = (b_inf & ~a_inf) | (a_zero & ~b_zero);
        sp_any  = sp_nan | sp_dz | sp_inf | sp_zero;
        if (sp_nan)
            sp_res = 32'h7fc00000;
        else if (sp_dz || sp_inf)
            sp_res = {sgn, 8'hff, 23'd0};
        else
            sp_res = {sgn, 31'd0};
    end

    // DIV step
    logic        rem_ge;
    logic [25:0] rem_sub;

    always_comb begin
        rem_ge  = rem_q >= {2'b00, mb_q};
        rem_sub = rem_ge ? (rem_q - {2'b00, mb_q}) : rem_q;
    end

    // ROUND datapath
    logic [5:0]  shamt;
    logic [57:0] wide;
    logic [23:0] mant;
    logic        g_b, r_b, st_b, inexact, inc, inc_n, tiny, ovf, ovf_max;
    logic [24:0] mant_r;
    logic [11:0] base_e;
    logic [34:0] mag;
    logic [31:0] fin_s;
    logic        fin_inv, fin_dz, fin_of, fin_uf, fin_nx;

    always_comb begin
        if (exp_q > 12'sd0)
            shamt = 6'd0;
        else if (exp_q < -12'sd25)
            shamt = 6'd27;
        else
            shamt = 6'(12'sd1 - exp_q);
        wide    = {quo_q, 32'd0} >> shamt;
        mant    = wide[57:34];
        g_b     = wide[33];
        r_b     = wide[32];
        st_b    = (|wide[31:0]) | (|rem_q);
        inexact = g_b | r_b | st_b;
        inc     = rnd_inc(rm_q, sign_q, mant[0], g_b, r_b, st_b);
        mant_r  = {1'b0, mant} + {24'd0, inc};
        base_e  = (exp_q > 12'sd0) ? 12'(exp_q - 12'sd1) : 12'd0;
        // a carry out of mant_r bumps the exponent field through the add
        mag     = {base_e, 23'd0} + {10'd0, mant_r};
        ovf     = mag >= 35'h07f800000;
        ovf_max = (rm_q == 2'b11) || (rm_q == 2'b01 && !sign_q) || (rm_q == 2'b10 && sign_q);
        // tininess judged as if the exponent range were unbounded
        inc_n   = rnd_inc(rm_q, sign_q, quo_q[2], quo_q[1], quo_q[0], |rem_q);
        tiny    = (exp_q < 12'sd1) && !((exp_q == 12'sd0) && inc_n && (&quo_q[25:2]));

        fin_s   = {sign_q, mag[30:0]};
        fin_inv = 1'b0;
        fin_dz  = 1'b0;
        fin_of  = 1'b0;
        fin_uf  = tiny & inexact;
        fin_nx  = inexact;
        if (spec_q) begin
            fin_s   = spec_res_q;
            fin_inv = spec_inv_q;
            fin_dz  = spec_dz_q;
            fin_uf  = 1'b0;
            fin_nx  = 1'b0;
        end else if (ovf) begin
            fin_s  = {sign_q, ovf_max ? 31'h7f7fffff : 31'h7f800000};
            fin_of = 1'b1;
            fin_uf = 1'b0;
            fin_nx = 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = PREP;
`ifdef FDIV_SPECIAL_FAST_EN
            PREP:  state_nx = sp_any ? IDLE : DIV;
`else
            PREP:  state_nx = DIV;
`endif
            DIV:   if (cnt_q == 5'd0) state_nx = ROUND;
            ROUND: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            rm_q       <= 2'd0;
            sign_q     <= 1'b0;
            exp_q      <= 12'sd0;
            mb_q       <= 24'd0;
            rem_q      <= 26'd0;
            quo_q      <= 26'd0;
            cnt_q      <= 5'd0;
            spec_q     <= 1'b0;
            spec_inv_q <= 1'b0;
            spec_dz_q  <= 1'b0;
            spec_res_q <= 32'd0;
            done       <= 1'b0;
            s          <= 32'd0;
            Invalid    <= 1'b0;
            DZ         <= 1'b0;
            OF         <= 1'b0;
            UF         <= 1'b0;
            NX         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q  <= a;
                        b_q  <= b;
                        rm_q <= rm;
                    end
                end
                PREP: begin
                    sign_q     <= sgn;
                    exp_q      <= ediff;
                    mb_q       <= mb;
                    rem_q      <= m_lt ? {1'b0, ma, 1'b0} : {2'b00, ma};
                    quo_q      <= 26'd0;
                    cnt_q      <= 5'd25;
                    spec_q     <= sp_any;
                    spec_inv_q <= sp_nan;
                    spec_dz_q  <= sp_dz & ~sp_nan;
                    spec_res_q <= sp_res;
`ifdef FDIV_SPECIAL_FAST_EN
                    if (sp_any) begin
                        s       <= sp_res;
                        Invalid <= sp_nan;
                        DZ      <= sp_dz & ~sp_nan;
                        OF      <= 1'b0;
                        UF      <= 1'b0;
                        NX      <= 1'b0;
                        done    <= 1'b1;
                    end
`endif
                end
                DIV: begin
                    rem_q <= {rem_sub[24:0], 1'b0};
                    quo_q <= {quo_q[24:0], rem_ge};
                    cnt_q <= cnt_q - 5'd1;
                end
                ROUND: begin
                    s       <= fin_s;
                    Invalid <= fin_inv;
                    DZ      <= fin_dz;
                    OF      <= fin_of;
                    UF      <= fin_uf;
                    NX      <= fin_nx;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv.sv
// Directed bench for fdiv: vector table plus hand-written busy/ignore/reset sequences.
module tb_fdiv;

    logic        clk, rst_n, start;
    logic [31:0] a, b;
    logic [1:0]  rm;
    logic        busy, done;
    logic [31:0] s;
    logic        Invalid, DZ, OF, UF, NX;

    int checks   = 0;
    int failures = 0;

    localparam logic [4:0] F_NX = 5'b00001, F_UF = 5'b00010, F_OF = 5'b00100,
                           F_DZ = 5'b01000, F_IV = 5'b10000;

    fdiv dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .rm(rm),
        .busy(busy), .done(done), .s(s),
        .Invalid(Invalid), .DZ(DZ), .OF(OF), .UF(UF), .NX(NX)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  rm;
        logic        sp;
        logic [31:0] s;
        logic [4:0]  f;
    } vec_t;

    vec_t vt [27];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [4:0] flags_now();
        return {Invalid, DZ, OF, UF, NX};
    endfunction

    // Called just before a rising edge; returns at the negedge where done is seen.
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                          input logic [1:0] irm, output int lat);
        a = ia; b = ib; rm = irm; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
    endtask

    function automatic int exp_lat(input logic sp);
`ifdef FDIV_SPECIAL_FAST_EN
        return sp ? 2 : 29;
`else
        return 29;
`endif
    endfunction

    initial begin
        int lat;
        int dcnt;

        vt[0]  = '{32'h3fc00000, 32'h3fc00000, 2'd0, 1'b0, 32'h3f800000, 5'd0};
        vt[1]  = '{32'h3f800000, 32'h40400000, 2'd0, 1'b0, 32'h3eaaaaab, F_NX};
        vt[2]  = '{32'h3f800000, 32'h40400000, 2'd1, 1'b0, 32'h3eaaaaaa, F_NX};
        vt[3]  = '{32'h3f800000, 32'h40400000, 2'd2, 1'b0, 32'h3eaaaaab, F_NX};
        vt[4]  = '{32'h3f800000, 32'h40400000, 2'd3, 1'b0, 32'h3eaaaaaa, F_NX};
        vt[5]  = '{32'h7f7fffff, 32'h00800000, 2'd0, 1'b0, 32'h7f800000, F_OF | F_NX};
        vt[6]  = '{32'h7f7fffff, 32'h00800000, 2'd3, 1'b0, 32'h7f7fffff, F_OF | F_NX};
        vt[7]  = '{32'h7f7fffff, 32'h00800000, 2'd1, 1'b0, 32'h7f7fffff, F_OF | F_NX};
        vt[8]  = '{32'h7f7fffff, 32'h00800000, 2'd2, 1'b0, 32'h7f800000, F_OF | F_NX};
        vt[9]  = '{32'hff7fffff, 32'h00800000, 2'd1, 1'b0, 32'hff800000, F_OF | F_NX};
        vt[10] = '{32'hff7fffff, 32'h00800000, 2'd2, 1'b0, 32'hff7fffff, F_OF | F_NX};
        vt[11] = '{32'h00800000, 32'h40000000, 2'd0, 1'b0, 32'h00400000, 5'd0};
        vt[12] = '{32'h00800000, 32'h40400000, 2'd0, 1'b0, 32'h002aaaab, F_UF | F_NX};
        vt[13] = '{32'h00800000, 32'h40400000, 2'd3, 1'b0, 32'h002aaaaa, F_UF | F_NX};
        vt[14] = '{32'h40c00000, 32'h40000000, 2'd0, 1'b0, 32'h40400000, 5'd0};
        vt[15] = '{32'h00000001, 32'h00000002, 2'd0, 1'b0, 32'h3f000000, 5'd0};
        vt[16] = '{32'h007fffff, 32'h3f800000, 2'd0, 1'b0, 32'h007fffff, 5'd0};
        vt[17] = '{32'hc0c00000, 32'h40000000, 2'd0, 1'b0, 32'hc0400000, 5'd0};
        vt[18] = '{32'hbf800000, 32'h40400000, 2'd1, 1'b0, 32'hbeaaaaab, F_NX};
        vt[19] = '{32'hbf800000, 32'h40400000, 2'd2, 1'b0, 32'hbeaaaaaa, F_NX};
        vt[20] = '{32'h3f800000, 32'h00000000, 2'd0, 1'b1, 32'h7f800000, F_DZ};
        vt[21] = '{32'hbf800000, 32'h00000000, 2'd0, 1'b1, 32'hff800000, F_DZ};
        vt[22] = '{32'h00000000, 32'h00000000, 2'd0, 1'b1, 32'h7fc00000, F_IV};
        vt[23] = '{32'h7f800000, 32'h7f800000, 2'd0, 1'b1, 32'h7fc00000, F_IV};
        vt[24] = '{32'h7f800001, 32'h3f800000, 2'd0, 1'b1, 32'h7fc00000, F_IV};
        vt[25] = '{32'h7f800000, 32'hc0000000, 2'd0, 1'b1, 32'hff800000, 5'd0};
        vt[26] = '{32'h80000000, 32'h40000000, 2'd0, 1'b1, 32'h80000000, 5'd0};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; rm = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_s", s, 32'd0);
        chk("reset_flags", {27'd0, flags_now()}, 32'd0);

        // first start coincides with reset release
        rst_n = 1'b1;
        for (int i = 0; i < 27; i++) begin
            run_op(vt[i].a, vt[i].b, vt[i].rm, lat);
            chk($sformatf("vec%0d_s", i), s, vt[i].s);
            chk($sformatf("vec%0d_flags", i), {27'd0, flags_now()}, {27'd0, vt[i].f});
            chk($sformatf("vec%0d_latency", i), lat, exp_lat(vt[i].sp));
        end

        // busy timing and start ignored while busy
        a = 32'h3fc00000; b = 32'h3fc00000; rm = 2'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk("busy_after_accept", {31'd0, busy}, 32'd1);
            if (lat == 5) begin
                a = 32'h3f800000; b = 32'h40400000; rm = 2'd2; start = 1'b1;
            end
            if (lat == 7) start = 1'b0;
            if (done) break;
        end
        chk("ignore_latency", lat, 29);
        chk("ignore_s", s, 32'h3f800000);
        chk("ignore_flags", {27'd0, flags_now()}, 32'd0);
        dcnt = 0;
        repeat (35) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("ignore_no_extra_done", dcnt, 0);
        chk("hold_s", s, 32'h3f800000);
        chk("hold_busy", {31'd0, busy}, 32'd0);

        // flags from an inexact op must not leak into the next exact one
        run_op(32'h3f800000, 32'h40400000, 2'd0, lat);
        chk("pre_flags", {27'd0, flags_now()}, {27'd0, F_NX});
        run_op(32'h40c00000, 32'h40000000, 2'd0, lat);
        chk("no_accum_flags", {27'd0, flags_now()}, 32'd0);

        // reset 10 cycles into a divide
        a = 32'h3f800000; b = 32'h40400000; rm = 2'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_s", s, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_flags", {27'd0, flags_now()}, 32'd0);
        dcnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("midrst_no_done", dcnt, 0);
        rst_n = 1'b1;
        run_op(32'h40c00000, 32'h40000000, 2'd0, lat);
        chk("postrst_latency", lat, 29);
        chk("postrst_s", s, 32'h40400000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
